// File: rtl/memarb_pkg.sv
// Shared definitions for the memory arbiter: issue-owner state encoding,
// default address width and data width.
package memarb_pkg;

  localparam int AW_DEFAULT = 12;
  localparam int DW         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IRD  = 2'd1,
    DRD  = 2'd2,
    DWR  = 2'd3
  } state_t;

endpackage

// File: rtl/m_memarb_if.sv
// Bundle of fetch port, data port and shared-memory signals for m_memarb.
// Stall counters exist only when MEMARB_STATS_EN is defined.
interface m_memarb_if import memarb_pkg::*; #(
  parameter int AW = AW_DEFAULT
) ();

  logic          w_ireq;
  logic [AW-1:0] w_iaddr;
  logic          w_istall;
  logic          r_ivalid;
  logic [DW-1:0] w_idata;

  logic          w_dreq;
  logic          w_dwe;
  logic [AW-1:0] w_daddr;
  logic [DW-1:0] w_ddin;
  logic          w_dstall;
  logic          r_dvalid;
  logic [DW-1:0] w_ddata;

  logic [AW-1:0] w_maddr;
  logic          w_mwe;
  logic [DW-1:0] w_mdin;
  logic [DW-1:0] w_mdout;

`ifdef MEMARB_STATS_EN
  logic [31:0]   r_istall_cnt;
  logic [31:0]   r_dstall_cnt;
`endif

  // Requesters and the external memory sit on the master side.
  modport master (
`ifdef MEMARB_STATS_EN
    input  r_istall_cnt, r_dstall_cnt,
`endif
    output w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    input  w_istall, r_ivalid, w_idata, w_dstall, r_dvalid, w_ddata,
    input  w_maddr, w_mwe, w_mdin
  );

  modport slave (
`ifdef MEMARB_STATS_EN
    output r_istall_cnt, r_dstall_cnt,
`endif
    input  w_ireq, w_iaddr, w_dreq, w_dwe, w_daddr, w_ddin, w_mdout,
    output w_istall, r_ivalid, w_idata, w_dstall, r_dvalid, w_ddata,
    output w_maddr, w_mwe, w_mdin
  );

endinterface

// File: rtl/m_memarb_starve.sv
// Counts consecutive stalled cycles of a requester and raises force_grant
// once the count reaches limit while the request is still pending.
module m_memarb_starve (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       request,
  input  logic       granted,
  input  logic [3:0] limit,
  output logic       force_grant
);

  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (!request || granted) begin
      cnt_next = 4'd0;
    end else if (cnt_reg < limit) begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      cnt_reg <= 4'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign force_grant = request && (cnt_reg == limit);

endmodule

// File: rtl/m_memarb.sv
// Two-port (fetch/data) arbiter onto one registered-read memory, data first
// with starvation relief for fetch. Define MEMARB_STATS_EN for stall counters.
module m_memarb import memarb_pkg::*; #(
  parameter int STARVE_MAX = 3,
  parameter int AW         = AW_DEFAULT
) (
  input logic       w_clk,
  input logic       w_rst,
  m_memarb_if.slave bus
);

  logic          fetch_grant;
  logic          data_grant;
  logic          force_grant;
  logic [AW-1:0] maddr;
  logic          mwe;
  logic          ivalid;
  logic          dvalid;
  state_t        state_reg;
  state_t        state_next;
  logic [DW-1:0] ihold_reg;
  logic [DW-1:0] dhold_reg;

  m_memarb_starve u_starve (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .request     (bus.w_ireq),
    .granted     (fetch_grant),
    .limit       (4'(STARVE_MAX)),
    .force_grant (force_grant)
  );

  always_comb begin
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    if (!w_rst) begin
      if (bus.w_ireq && (!bus.w_dreq || force_grant)) begin
        fetch_grant = 1'b1;
      end else if (bus.w_dreq) begin
        data_grant = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    maddr      = '0;
    mwe        = 1'b0;
    if (fetch_grant) begin
      state_next = IRD;
      maddr      = bus.w_iaddr;
    end else if (data_grant) begin
      state_next = bus.w_dwe ? DWR : DRD;
      maddr      = bus.w_daddr;
      mwe        = bus.w_dwe;
    end
  end

  // Valids are masked by reset so a read issued just before reset never surfaces.
  assign ivalid = (state_reg == IRD) && !w_rst;
  assign dvalid = (state_reg == DRD) && !w_rst;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_reg <= IDLE;
      ihold_reg <= '0;
      dhold_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (ivalid) ihold_reg <= bus.w_mdout;
      if (dvalid) dhold_reg <= bus.w_mdout;
    end
  end

  assign bus.w_maddr  = maddr;
  assign bus.w_mwe    = mwe;
  assign bus.w_mdin   = bus.w_ddin;
  assign bus.w_istall = bus.w_ireq && !fetch_grant;
  assign bus.w_dstall = bus.w_dreq && !data_grant;
  assign bus.r_ivalid = ivalid;
  assign bus.r_dvalid = dvalid;
  assign bus.w_idata  = ivalid ? bus.w_mdout : ihold_reg;
  assign bus.w_ddata  = dvalid ? bus.w_mdout : dhold_reg;

`ifdef MEMARB_STATS_EN
  logic [1:0]  stall_vec;
  logic [31:0] stall_cnt_reg [2];

  assign stall_vec = {bus.w_dstall, bus.w_istall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stall_cnt
    always_ff @(posedge w_clk) begin
      if (w_rst) begin
        stall_cnt_reg[gi] <= '0;
      end else if (stall_vec[gi] && (stall_cnt_reg[gi] != '1)) begin
        stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign bus.r_istall_cnt = stall_cnt_reg[0];
  assign bus.r_dstall_cnt = stall_cnt_reg[1];
`endif

endmodule

// File: tb/tb_m_memarb.sv
// Directed scoreboard bench for m_memarb: stimulus queues expected read data,
// a negedge monitor pops and compares on every valid pulse.
module tb_m_memarb;
  import memarb_pkg::*;

  localparam int AW = 12;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;

  m_memarb_if #(.AW(AW)) bus ();

  m_memarb #(.STARVE_MAX(3), .AW(AW)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 w_clk = ~w_clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] wmem[int];

  // Unwritten words read back as 0xC0DE0000 | address.
  always @(posedge w_clk) begin
    if (bus.w_mwe === 1'b1) wmem[int'(bus.w_maddr)] = bus.w_mdin;
    bus.w_mdout <= wmem.exists(int'(bus.w_maddr)) ? wmem[int'(bus.w_maddr)]
                                                  : (32'hC0DE_0000 | 32'(bus.w_maddr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge w_clk);
    #1;
  endtask

  task automatic drive(input logic ireq, input logic [AW-1:0] iaddr, input logic dreq,
                       input logic dwe, input logic [AW-1:0] daddr, input logic [31:0] ddin);
    bus.w_ireq  = ireq;
    bus.w_iaddr = iaddr;
    bus.w_dreq  = dreq;
    bus.w_dwe   = dwe;
    bus.w_daddr = daddr;
    bus.w_ddin  = ddin;
  endtask

  always @(negedge w_clk) begin
    if (bus.r_ivalid === 1'b1) begin
      if (iq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected: got valid data %h expected no valid", bus.w_idata);
      end else begin
        $display("fetch read  data=%h expected=%h", bus.w_idata, iq[0]);
        check("fetch_data", bus.w_idata, iq.pop_front());
      end
    end
    if (bus.r_dvalid === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_unexpected: got valid data %h expected no valid", bus.w_ddata);
      end else begin
        $display("data  read  data=%h expected=%h", bus.w_ddata, dq[0]);
        check("data_read", bus.w_ddata, dq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fetch_pat;
    fetch_pat = 8'b1000_1000;

    // Requests during reset: nothing granted, stalls follow requests.
    drive(1'b1, 12'd0, 1'b1, 1'b1, 12'd9, 32'hDEAD_BEEF);
    @(negedge w_clk);
    check("rst_istall", 32'(bus.w_istall), 32'd1);
    check("rst_dstall", 32'(bus.w_dstall), 32'd1);
    check("rst_mwe", 32'(bus.w_mwe), 32'd0);
    step();
    step();
    w_rst = 1'b0;
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    @(negedge w_clk);
    check("rst_ivalid", 32'(bus.r_ivalid), 32'd0);
    check("rst_dvalid", 32'(bus.r_dvalid), 32'd0);
    check("rst_idata", bus.w_idata, 32'd0);
    check("rst_ddata", bus.w_ddata, 32'd0);
    step();

    // Back-to-back fetches at 0,1,2.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 12'(i), 1'b0, 1'b0, 12'd0, 32'd0);
      @(negedge w_clk);
      check("fetch_istall", 32'(bus.w_istall), 32'd0);
      check("fetch_maddr", 32'(bus.w_maddr), 32'(i));
      iq.push_back(32'hC0DE_0000 | 32'(i));
      step();
    end

    // Write and fetch to address 5 collide: write wins.
    drive(1'b1, 12'd5, 1'b1, 1'b1, 12'd5, 32'h0000_1234);
    @(negedge w_clk);
    check("wr_istall", 32'(bus.w_istall), 32'd1);
    check("wr_dstall", 32'(bus.w_dstall), 32'd0);
    check("wr_mwe", 32'(bus.w_mwe), 32'd1);
    check("wr_maddr", 32'(bus.w_maddr), 32'd5);
    check("wr_mdin", bus.w_mdin, 32'h0000_1234);
    step();
    drive(1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 32'd0);
    @(negedge w_clk);
    check("refetch_istall", 32'(bus.w_istall), 32'd0);
    iq.push_back(32'h0000_1234);
    step();
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd2, 32'd0);
    @(negedge w_clk);
    check("dread_dstall", 32'(bus.w_dstall), 32'd0);
    check("dread_mwe", 32'(bus.w_mwe), 32'd0);
    dq.push_back(32'hC0DE_0002);
    step();

    // Idle: outputs hold the last delivered words.
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    step();
    @(negedge w_clk);
    check("idle_mwe", 32'(bus.w_mwe), 32'd0);
    check("idle_maddr", 32'(bus.w_maddr), 32'd0);
    check("idle_ivalid", 32'(bus.r_ivalid), 32'd0);
    check("idle_dvalid", 32'(bus.r_dvalid), 32'd0);
    check("idle_idata", bus.w_idata, 32'h0000_1234);
    check("idle_ddata", bus.w_ddata, 32'hC0DE_0002);
    step();

    // Data read issued, then reset: the read must never show up.
    drive(1'b0, 12'd0, 1'b1, 1'b0, 12'd3, 32'd0);
    @(negedge w_clk);
    check("midrd_dstall", 32'(bus.w_dstall), 32'd0);
    step();
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    w_rst = 1'b1;
    @(negedge w_clk);
    check("midrd_dvalid_rst", 32'(bus.r_dvalid), 32'd0);
    step();
    w_rst = 1'b0;
    @(negedge w_clk);
    check("midrd_dvalid_after", 32'(bus.r_dvalid), 32'd0);
    check("midrd_ivalid_after", 32'(bus.r_ivalid), 32'd0);
    check("midrd_ddata_cleared", bus.w_ddata, 32'd0);
    step();

    // Both ports held: three data grants, one forced fetch, repeat.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 12'd8, 1'b1, 1'b0, 12'd7, 32'd0);
      @(negedge w_clk);
      check("starve_istall", 32'(bus.w_istall), 32'(!fetch_pat[k]));
      check("starve_dstall", 32'(bus.w_dstall), 32'(fetch_pat[k]));
      if (fetch_pat[k]) iq.push_back(32'hC0DE_0008);
      else              dq.push_back(32'hC0DE_0007);
      step();
    end
    drive(1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 32'd0);
    @(negedge w_clk);
`ifdef MEMARB_STATS_EN
    check("stats_istall_cnt", bus.r_istall_cnt, 32'd6);
    check("stats_dstall_cnt", bus.r_dstall_cnt, 32'd2);
`endif
    step();
    step();
    @(negedge w_clk);
    check("fetch_queue_drained", 32'(iq.size()), 32'd0);
    check("data_queue_drained", 32'(dq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_memarb.md
M_MEMARB -- requirements
Module: m_memarb

Interface
REQ-001 Parameter STARVE_MAX, 3, consecutive fetch stall cycles before the fetch port is forced a grant; legal range 1..15.
REQ-002 Parameter AW, 12, word-address width of the shared memory.
REQ-003 w_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 w_rst  in  1  reset, synchronous, active-high.
REQ-005 w_ireq  in  1  fetch port read request.
REQ-006 w_iaddr  in  AW  fetch word address.
REQ-007 w_istall  out  1  fetch request not granted this cycle.
REQ-008 r_ivalid  out  1  fetch read data valid.
REQ-009 w_idata  out  32  fetch read data.
REQ-010 w_dreq  in  1  data port request.
REQ-011 w_dwe  in  1  data write enable, qualified by w_dreq.
REQ-012 w_daddr  in  AW  data word address.
REQ-013 w_ddin  in  32  data write value.
REQ-014 w_dstall  out  1  data request not granted this cycle.
REQ-015 r_dvalid  out  1  data read data valid; reads only.
REQ-016 w_ddata  out  32  data read data.
REQ-017 w_maddr  out  AW  shared memory address.
REQ-018 w_mwe  out  1  shared memory write enable.
REQ-019 w_mdin  out  32  shared memory write data.
REQ-020 w_mdout  in  32  shared memory read data; registered, valid one cycle after the address edge.

Function
REQ-021 At most one access is granted per cycle; grant is combinational from the current requests and the starvation count.
REQ-022 Data port has priority: w_dreq=1 grants data unless the starvation count equals STARVE_MAX with w_ireq=1, in which case fetch is granted.
REQ-023 Granted port drives w_maddr; w_mwe=w_dreq&w_dwe only on a data grant; w_mwe=0 and w_maddr=0 when nothing is granted.
REQ-024 w_istall=w_ireq&~fetch grant; w_dstall=w_dreq&~data grant.
REQ-025 Issue-owner FSM states IDLE, IRD, DRD, DWR record the access issued at the last edge; next state follows the current grant (fetch to IRD, data read to DRD, data write to DWR, none to IDLE).
REQ-026 r_ivalid=1 exactly in state IRD; r_dvalid=1 exactly in state DRD; both 0 in IDLE and DWR; read latency is one cycle.
REQ-027 w_idata/w_ddata equal w_mdout while the matching valid is 1; otherwise each holds the last value it delivered.
REQ-028 Starvation count (4 bit) increments when w_ireq=1 and fetch is not granted, clears when fetch is granted or w_ireq=0, and never exceeds STARVE_MAX.
REQ-029 Write and fetch to the same address in the same cycle: write granted, fetch stalls; the fetch issued on a later cycle returns the new value.
REQ-030 Back-to-back grants to the same port are allowed every cycle with no bubble.

Reset
REQ-031 w_rst=1 at an edge forces state IDLE, r_ivalid=0, r_dvalid=0, starvation count 0, hold registers 0.
REQ-032 A read in flight when reset is asserted is discarded: no valid pulse follows.
REQ-033 While w_rst=1, no grant is given, w_mwe=0, and both stalls follow their requests.

Configuration
REQ-034 With MEMARB_STATS_EN defined: 32-bit output counters r_istall_cnt and r_dstall_cnt increment each cycle the matching stall is 1, saturate at all-ones, and clear on reset.
REQ-035 Without MEMARB_STATS_EN: those ports and counters do not exist, and all other behaviour is identical.

Structure
REQ-036 Shared package memarb_pkg holds the FSM state encoding (IDLE=0, IRD=1, DRD=2, DWR=3), the default AW and the 32-bit data width constant.
REQ-037 The starvation counter is one sub-module, m_memarb_starve (inputs: request, granted, limit; output: force-grant).
REQ-038 The memory itself is outside the block.

Verification
REQ-039 Fetch-only: w_ireq=1 at addresses 0,1,2 on consecutive cycles -> no stall; r_ivalid=1 on the three following cycles with the memory words at 0,1,2.
REQ-040 Write then read: data write 0x1234 to address 5 while w_ireq=1 to address 5 -> w_istall=1 and w_mwe=1 that cycle; the next fetch returns 0x1234.
REQ-041 Starvation: w_dreq=w_ireq=1 held with STARVE_MAX=3 -> three data grants, then one fetch grant with w_dstall=1, then the pattern repeats.
REQ-042 Reset mid-read: data read granted, w_rst=1 at the next edge -> r_dvalid stays 0 and the FSM is IDLE.
REQ-043 Idle: no requests -> w_mwe=0, both valids 0, and the data outputs hold their last values.
REQ-044 With MEMARB_STATS_EN: run the REQ-041 scenario for 8 cycles -> r_istall_cnt=6 and r_dstall_cnt=2.
